// File: rtl/display_pkg.sv
// Shared front-panel display definitions: blanking pattern, active-low
// seven-segment glyphs (bit order gfedcba) and a one-hot test helper.
package display_pkg;

    localparam logic [6:0] SEG_OFF     = 7'h7F;
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // True when exactly one bit of the (zero-extended) vector is set.
    function automatic logic is_onehot(input logic [63:0] vec);
        return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot to binary index encoder with a validity flag. The index is only
// meaningful when valid is high; otherwise it is the OR of all set positions.
module onehot_to_idx
    import display_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]         vec,
    output logic [$clog2(W)-1:0] idx,
    output logic                 valid
);

    // OR-encode set bit positions and flag the exactly-one-set case.
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx = idx | ($clog2(W))'(i);
            end
        end
        valid = is_onehot(64'(vec));
    end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Shared seven-segment scanner for the front panel: refresh timing,
// anti-ghost blanking at the start of each digit slot, and source switching
// that only happens on the frame boundary.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | first BLANK_CYC cycles of a slot, all anodes off
//   ST_DRIVE | rest of the slot, one digit lit from the current source
//
// The state tracks the counters; AN/led are registered from the current
// counter/state values, so the pins lag the counters by one cycle.
module seg_scan_arbiter
    import display_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int NUM_DIGITS  = 8,
    parameter int SEG_W       = 7,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 sel,
    input  logic [NUM_SRC*NUM_DIGITS*SEG_W-1:0] src_seg,
    input  logic                               blank,
    output logic [NUM_DIGITS-1:0]              AN,
    output logic [SEG_W-1:0]                   led,
    output logic [$clog2(NUM_SRC)-1:0]         cur_src,
    output logic                               sel_err,
    output logic                               frame_start
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYC);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      slot_cnt_q,    slot_cnt_d;
    logic [DIG_W-1:0]      digit_idx_q,   digit_idx_d;
    scan_state_e           state_q,       state_d;
    logic [SRC_W-1:0]      pending_src_q, pending_src_d;
    logic [SRC_W-1:0]      cur_src_q,     cur_src_d;
    logic                  sel_err_q,     sel_err_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0] an_q,          an_d;
    logic [SEG_W-1:0]      led_q,         led_d;

    logic [SRC_W-1:0]      sel_idx;
    logic                  sel_valid;
    logic                  last_slot;
    logic                  last_digit;
    logic                  boundary;
    logic [SEG_W-1:0]      seg_pick;

    onehot_to_idx #(
        .W (NUM_SRC)
    ) u_sel_enc (
        .vec   (sel),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Next-state logic for counters, scan FSM, source arbitration and pins.
    always_comb begin
        last_slot  = (slot_cnt_q == SLOT_LAST);
        last_digit = (digit_idx_q == DIGIT_LAST);
        boundary   = last_slot && last_digit;

        slot_cnt_d  = last_slot ? '0 : slot_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (last_slot) begin
            digit_idx_d = last_digit ? '0 : digit_idx_q + DIG_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (slot_cnt_d == BLANK_END) state_d = ST_DRIVE;
            ST_DRIVE: if (last_slot)               state_d = ST_BLANK;
            default:                               state_d = ST_BLANK;
        endcase

        // An invalid request keeps the last good one pending.
        pending_src_d = sel_valid ? sel_idx : pending_src_q;
        sel_err_d     = !sel_valid;

        // The request sampled on the boundary cycle itself still counts.
        cur_src_d     = boundary ? pending_src_d : cur_src_q;
        frame_start_d = boundary;

        seg_pick = src_seg[(int'(cur_src_q) * NUM_DIGITS + int'(digit_idx_q)) * SEG_W +: SEG_W];

        an_d  = '1;
        led_d = '1;
        if ((state_q == ST_DRIVE) && !blank) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
            led_d = seg_pick;
        end
    end

    // State and output registers; reset darkens the panel immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            state_q       <= ST_BLANK;
            pending_src_q <= '0;
            cur_src_q     <= '0;
            sel_err_q     <= 1'b0;
            frame_start_q <= 1'b0;
            an_q          <= '1;
            led_q         <= '1;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            state_q       <= state_d;
            pending_src_q <= pending_src_d;
            cur_src_q     <= cur_src_d;
            sel_err_q     <= sel_err_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            led_q         <= led_d;
        end
    end

    assign AN          = an_q;
    assign led         = led_q;
    assign cur_src     = cur_src_q;
    assign sel_err     = sel_err_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter with a small configuration (4 sources,
// 4 digits, 4-cycle slots, 1 dark cycle). The reference model works on the
// absolute cycle count since reset release.
module tb_seg_scan_arbiter;

    localparam int NS  = 4;
    localparam int ND  = 4;
    localparam int SW  = 7;
    localparam int RD  = 4;
    localparam int BC  = 1;
    localparam int FRM = ND * RD;

    logic                  clk;
    logic                  rst_n;
    logic [NS-1:0]         sel;
    logic [NS*ND*SW-1:0]   src_seg;
    logic                  blank;
    logic [ND-1:0]         AN;
    logic [SW-1:0]         led;
    logic [1:0]            cur_src;
    logic                  sel_err;
    logic                  frame_start;

    int n_vec;
    int n_err;
    int k;
    int mdl_pending;
    int mdl_cur;

    seg_scan_arbiter #(
        .NUM_SRC     (NS),
        .NUM_DIGITS  (ND),
        .SEG_W       (SW),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .src_seg     (src_seg),
        .blank       (blank),
        .AN          (AN),
        .led         (led),
        .cur_src     (cur_src),
        .sel_err     (sel_err),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] seg_of(input logic [NS*ND*SW-1:0] v, input int s, input int d);
        return v[(s * ND + d) * SW +: SW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One clock: predict pins for the next cycle from the current inputs,
    // let the edge happen, then compare.
    task automatic step();
        int            slot;
        int            dig;
        bit            dark;
        logic [ND-1:0] one;
        logic [ND-1:0] exp_an;
        logic [SW-1:0] exp_led;
        logic          exp_err;
        logic          exp_fs;
        slot    = k % RD;
        dig     = (k / RD) % ND;
        dark    = blank || (slot < BC);
        one     = 4'b0001;
        exp_an  = dark ? 4'hF : ~(one << dig);
        exp_led = dark ? 7'h7F : seg_of(src_seg, mdl_cur, dig);
        exp_err = ($countones(sel) != 1);
        if (!exp_err) begin
            for (int i = 0; i < NS; i++) if (sel[i]) mdl_pending = i;
        end
        exp_fs = ((k % FRM) == FRM - 1);
        if (exp_fs) mdl_cur = mdl_pending;
        @(posedge clk);
        #1;
        chk("AN", 32'(AN), 32'(exp_an));
        chk("led", 32'(led), 32'(exp_led));
        chk("sel_err", 32'(sel_err), 32'(exp_err));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("cur_src", 32'(cur_src), 32'(mdl_cur));
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset asynchronously, check the panel goes dark at once, then
    // release between edges so the next rising edge ends cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_AN", 32'(AN), 32'hF);
        chk("rst_led", 32'(led), 32'h7F);
        chk("rst_cur_src", 32'(cur_src), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        k           = 0;
        mdl_pending = 0;
        mdl_cur     = 0;
    endtask

    task automatic rand_src_seg();
        logic [127:0] r;
        r       = {$urandom, $urandom, $urandom, $urandom};
        src_seg = r[NS*ND*SW-1:0];
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        k           = 0;
        mdl_pending = 0;
        mdl_cur     = 0;
        rst_n       = 1'b1;
        sel         = 4'b0001;
        blank       = 1'b0;
        rand_src_seg();
        src_seg[0*SW +: SW] = 7'h01;
        src_seg[1*SW +: SW] = 7'h02;
        src_seg[2*SW +: SW] = 7'h03;
        src_seg[3*SW +: SW] = 7'h04;
        #2;

        // Power-on reset, then idle on source 0.
        do_reset();
        run(5);

        // Mid-frame switch to source 2; takes effect at the boundary.
        sel = 4'b0100;
        run(30);

        // Non-one-hot request for three cycles, then source 3.
        sel = 4'b0110;
        run(3);
        sel = 4'b1000;
        run(20);

        // No request across a boundary: source holds.
        sel = 4'b0000;
        run(20);

        // Blank for 10 cycles starting inside a DRIVE phase.
        sel = 4'b0001;
        for (int i = 0; i < RD && (k % RD) != 2; i++) step();
        blank = 1'b1;
        run(10);
        blank = 1'b0;
        run(20);

        // Randomised requests, blanking and live pattern changes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) sel = 4'(1 << $urandom_range(0, NS - 1));
            else                           sel = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) rand_src_seg();
            step();
        end
        blank = 1'b0;

        // Reset in the middle of digit 2's DRIVE phase on a non-zero source.
        sel = 4'b0100;
        run(FRM);
        for (int i = 0; i < FRM && (k % FRM) != 10; i++) step();
        chk("pre_rst_AN", 32'(AN), 32'hB);
        do_reset();
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
